// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions.
// Holds the controller state encoding used by the serial arithmetic
// controllers (adder today, multiplier/subtractor later).
package arith_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } ctrl_state_t;

endpackage

// File: rtl/fa_cell.sv
// Combinational full adder built from two half adders with their carries ORed.
// Ports: a, b, cin (inputs); s = a ^ b ^ cin, cout = majority(a, b, cin).
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1, c1, c2;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s1),
    .c (c1)
  );

  half_adder u_ha1 (
    .a (s1),
    .b (cin),
    .s (s),
    .c (c2)
  );

  assign cout = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// Half adder: one-bit sum and carry of two inputs.
// Ports: a, b (inputs); s = a ^ b, c = a & b (outputs).
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder cell processes the operands LSB first,
// one bit per clock, producing {cout, sum} = a + b + cin after WIDTH RUN cycles.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           request, accepted in IDLE or DONE only
//   a, b, cin       operands, captured on an accepted start
//   busy            high while computing
//   done            one-cycle pulse when sum/cout are updated
//   sum, cout       registered result, held until the next completion
module serial_adder_ctrl
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  ctrl_state_t      state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_b_q, psum_q, psum_d, sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, cout_q;
  logic             fa_s, fa_c;
  logic             accept, last_bit;

  fa_cell u_fa (
    .a    (op_a_q[0]),
    .b    (op_b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  // New sum bit enters at the MSB so the LSB-first stream ends up in order.
  if (WIDTH == 1) begin : g_psum_w1
    assign psum_d = fa_s;
  end else begin : g_psum_wn
    assign psum_d = {fa_s, psum_q[WIDTH-1:1]};
  end

  assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      op_a_q  <= a;
      op_b_q  <= b;
      carry_q <= cin;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      op_a_q  <= op_a_q >> 1;
      op_b_q  <= op_b_q >> 1;
      carry_q <= fa_c;
      psum_q  <= psum_d;
      cnt_q   <= cnt_q + CNT_W'(1);
      // Publish on the final bit so sum/cout stay stable between completions.
      if (last_bit) begin
        sum_q  <= psum_d;
        cout_q <= fa_c;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1 instances).
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  logic start1, a1, b1, cin1;
  logic busy1, done1, cout1;
  logic sum1;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] hold_sum;
  logic         hold_cout;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; sample/drive 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
  endtask

  task automatic check_held(input string tag);
    check_eq({tag, "_sum_hold"}, 32'(sum), 32'(hold_sum));
    check_eq({tag, "_cout_hold"}, 32'(cout), 32'(hold_cout));
  endtask

  // One addition: start is presented for the E0 edge; done expected after E(W).
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input bit keep_start, input bit noisy);
    logic [W:0] expv;
    expv  = {1'b0, av} + {1'b0, bv} + (W+1)'(cv);
    a     = av;
    b     = bv;
    cin   = cv;
    start = 1'b1;
    step();
    for (int k = 1; k <= W; k++) begin
      start = keep_start ? 1'b1 : 1'($urandom);
      if (noisy) scramble_inputs();
      check_eq("run_busy", 32'(busy), 32'd1);
      check_eq("run_done", 32'(done), 32'd0);
      check_held("run");
      if (k == W) start = keep_start;
      step();
    end
    check_eq("done_pulse", 32'(done), 32'd1);
    check_eq("done_busy", 32'(busy), 32'd0);
    check_eq("result_sum", 32'(sum), 32'(expv[W-1:0]));
    check_eq("result_cout", 32'(cout), 32'(expv[W]));
    hold_sum  = expv[W-1:0];
    hold_cout = expv[W];
  endtask

  task automatic idle_cycles(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      scramble_inputs();
      check_eq("idle_busy", 32'(busy), 32'd0);
      check_eq("idle_done", 32'(done), 32'd0);
      check_held("idle");
    end
  endtask

  initial begin
    logic [W:0] r1;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    step();
    step();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_sum", 32'(sum), 32'd0);
    check_eq("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    hold_sum = '0;
    hold_cout = 1'b0;
    idle_cycles(1);

    // Directed vectors.
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
    idle_cycles(1);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    idle_cycles(1);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
    idle_cycles(2);

    // start held high: back-to-back with no idle bubble.
    run_op(8'h10, 8'h20, 1'b0, 1'b1, 1'b1);
    run_op(8'h7F, 8'h01, 1'b0, 1'b1, 1'b1);
    idle_cycles(1);

    // Abort in the 4th RUN cycle of 0x55 + 0xAA.
    a = 8'h55; b = 8'hAA; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    check_eq("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_sum", 32'(sum), 32'd0);
    check_eq("abort_cout", 32'(cout), 32'd0);
    hold_sum = '0;
    hold_cout = 1'b0;
    idle_cycles(2);
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
    r1 = {hold_cout, hold_sum};
    check_eq("post_abort_result", 32'(r1), 32'h002);

    // Randomized operations with noisy inputs and random gaps (0 = back-to-back).
    for (int t = 0; t < 40; t++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      run_op(W'($urandom), W'($urandom), 1'($urandom), gap == 0, 1'b1);
      if (gap != 0) idle_cycles(gap);
    end
    idle_cycles(1);

    // WIDTH=1 instance: all eight operand combinations.
    for (int v = 0; v < 8; v++) begin
      logic [1:0] e1;
      a1 = v[0]; b1 = v[1]; cin1 = v[2];
      e1 = 2'(a1) + 2'(b1) + 2'(cin1);
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
      check_eq("w1_busy", 32'(busy1), 32'd1);
      check_eq("w1_done_early", 32'(done1), 32'd0);
      step();
      check_eq("w1_done", 32'(done1), 32'd1);
      check_eq("w1_busy_off", 32'(busy1), 32'd0);
      check_eq("w1_result", 32'({cout1, sum1}), 32'(e1));
      step();
      check_eq("w1_done_clear", 32'(done1), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
